// File: rtl/switch_bounce_pkg.sv
// ---------------------------------------------------------------------------
// switch_bounce_pkg
// Shared definitions for the mechanical-switch bounce emulator.
//   bounce_state_e : sequencer states (idle, bounce on/off, settled hold, done)
//   LFSR_W         : width of the pseudo-random generator
//   LFSR_TAPS      : Galois toggle mask of the generator
//   DEFAULT_SEED   : reset value used when the top is not given another seed
//   safe_seed()    : maps an all-zero seed to 1 (a zero LFSR would lock up)
// ---------------------------------------------------------------------------
package switch_bounce_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ON   = 3'd1,
    ST_OFF  = 3'd2,
    ST_HOLD = 3'd3,
    ST_DONE = 3'd4
  } bounce_state_e;

  localparam int                LFSR_W       = 32;
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 32'h8020_0003;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 32'hACE1_0001;

  // A Galois LFSR stuck at zero never leaves it, so zero seeds become 1.
  function automatic logic [LFSR_W-1:0] safe_seed(input logic [LFSR_W-1:0] seed);
    return (seed == '0) ? LFSR_W'(1) : seed;
  endfunction

endpackage

// File: rtl/switch_bounce_gen_lfsr.sv
// ---------------------------------------------------------------------------
// lfsr_galois
// Right-shifting Galois LFSR. Each step shifts the state one place towards
// bit 0; when the bit shifted out is 1 the TAPS mask is XORed into the
// shifted value. With TAPS[WIDTH-1] set the state can never become zero.
// Parameters:
//   WIDTH : register width
//   TAPS  : Galois toggle mask
//   SEED  : reset value (zero is replaced by 1)
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, loads SEED
//   en    : advance one step per cycle while high
//   value : current register contents (parallel out)
// ---------------------------------------------------------------------------
module lfsr_galois #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(1),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? WIDTH'(1) : SEED;

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] state_next;

  // Per-bit next state: the neighbour above, toggled by the feedback bit
  // wherever the tap mask is set. The top bit only receives feedback.
  for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
    assign state_next[gi] = state[gi+1] ^ (state[0] & TAPS[gi]);
  end
  assign state_next[WIDTH-1] = state[0] & TAPS[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED_NZ;
    end else if (en) begin
      state <= state_next;
    end
  end

  assign value = state;

endmodule

// File: rtl/switch_bounce_gen.sv
// ---------------------------------------------------------------------------
// switch_bounce_gen
// Mechanical-switch emulator. On request it drives sw_o through a number of
// glitch pairs (target level, then inverted level) of pseudo-random length
// and finally holds the target level before reporting completion.
// Parameters:
//   CNT_W : width of all duration fields and of the phase counter
//   SEED  : LFSR reset value (zero is replaced by 1)
// Ports:
//   clk_i         : clock, rising edge
//   rst_ni        : asynchronous active-low reset
//   start_i       : start request, honoured only in IDLE or DONE
//   level_i       : settled level of sw_o
//   num_bounces_i : glitch pairs before settling (0 = settle immediately)
//   min_len_i     : minimum glitch phase length (0 behaves as 1)
//   rand_mask_i   : mask on the LFSR bits forming the random part of a phase
//   hold_i        : settled hold length (0 behaves as 1)
//   sw_o          : emulated switch line (registered)
//   busy_o        : sequence in progress (registered)
//   done_o        : one-cycle completion pulse (registered)
// ---------------------------------------------------------------------------
module switch_bounce_gen
  import switch_bounce_pkg::*;
#(
  parameter int                CNT_W = 24,
  parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             level_i,
  input  logic [7:0]       num_bounces_i,
  input  logic [CNT_W-1:0] min_len_i,
  input  logic [CNT_W-1:0] rand_mask_i,
  input  logic [CNT_W-1:0] hold_i,
  output logic             sw_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // -------------------------------------------------------------------------
  // Free-running random source
  // -------------------------------------------------------------------------
  logic [LFSR_W-1:0] lfsr_value;
  logic [CNT_W-1:0]  rand_bits;

  lfsr_galois #(
    .WIDTH (LFSR_W),
    .TAPS  (LFSR_TAPS),
    .SEED  (safe_seed(SEED))
  ) u_lfsr (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .en    (1'b1),
    .value (lfsr_value)
  );

  // The random part uses the low CNT_W LFSR bits; wider counters see the
  // LFSR zero-extended.
  if (CNT_W < LFSR_W) begin : g_rand_trunc
    assign rand_bits = lfsr_value[CNT_W-1:0];
    logic unused_lfsr_hi;
    assign unused_lfsr_hi = ^lfsr_value[LFSR_W-1:CNT_W];
  end else begin : g_rand_ext
    assign rand_bits = CNT_W'(lfsr_value);
  end

  // -------------------------------------------------------------------------
  // Sequencer state and latched configuration
  // -------------------------------------------------------------------------
  bounce_state_e    state;
  logic [CNT_W-1:0] phase_cnt;   // cycles left in the current phase, ends at 1
  logic [7:0]       bounce_cnt;  // glitch pairs still to emit
  logic             cfg_level;
  logic [CNT_W-1:0] cfg_min;
  logic [CNT_W-1:0] cfg_mask;
  logic [CNT_W-1:0] cfg_hold;

  logic             accept;
  logic             phase_last;

  assign accept     = start_i && ((state == ST_IDLE) || (state == ST_DONE));
  assign phase_last = (phase_cnt == ONE);

  // -------------------------------------------------------------------------
  // Phase length: max(min,1) + (lfsr & mask), saturated.
  // On the accepting cycle the configuration registers are still being
  // loaded, so the first phase is sized straight from the inputs.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] sel_min;
  logic [CNT_W-1:0] sel_mask;
  logic [CNT_W-1:0] sel_hold;
  logic [CNT_W-1:0] min_eff;
  logic [CNT_W-1:0] hold_eff;
  logic [CNT_W:0]   len_sum;
  logic [CNT_W-1:0] phase_len;

  always_comb begin
    sel_min   = accept ? min_len_i   : cfg_min;
    sel_mask  = accept ? rand_mask_i : cfg_mask;
    sel_hold  = accept ? hold_i      : cfg_hold;
    min_eff   = (sel_min == '0)  ? ONE : sel_min;
    hold_eff  = (sel_hold == '0) ? ONE : sel_hold;
    // One extra bit catches the carry so the sum can clamp to all ones
    // instead of wrapping to a short phase.
    len_sum   = {1'b0, min_eff} + {1'b0, rand_bits & sel_mask};
    phase_len = len_sum[CNT_W] ? '1 : len_sum[CNT_W-1:0];
  end

  // -------------------------------------------------------------------------
  // Sequencer. Every output is a register updated on the transition into a
  // state, so a phase of length d shows its level for exactly d cycles and
  // the next level follows without a gap.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      phase_cnt  <= '0;
      bounce_cnt <= '0;
      cfg_level  <= 1'b0;
      cfg_min    <= '0;
      cfg_mask   <= '0;
      cfg_hold   <= '0;
      sw_o       <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        // DONE accepts a new request exactly like IDLE, which gives the
        // single non-busy cycle between back-to-back sequences.
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            cfg_level  <= level_i;
            cfg_min    <= min_len_i;
            cfg_mask   <= rand_mask_i;
            cfg_hold   <= hold_i;
            bounce_cnt <= num_bounces_i;
            sw_o       <= level_i;
            busy_o     <= 1'b1;
            if (num_bounces_i == 8'd0) begin
              state     <= ST_HOLD;
              phase_cnt <= hold_eff;
            end else begin
              state     <= ST_ON;
              phase_cnt <= phase_len;
            end
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_ON: begin
          if (phase_last) begin
            state     <= ST_OFF;
            phase_cnt <= phase_len;
            sw_o      <= ~cfg_level;
          end else begin
            phase_cnt <= phase_cnt - ONE;
          end
        end

        ST_OFF: begin
          if (phase_last) begin
            bounce_cnt <= bounce_cnt - 8'd1;
            sw_o       <= cfg_level;
            // Testing the pre-decrement value for 1 is the same as testing
            // the decremented count for 0.
            if (bounce_cnt == 8'd1) begin
              state     <= ST_HOLD;
              phase_cnt <= hold_eff;
            end else begin
              state     <= ST_ON;
              phase_cnt <= phase_len;
            end
          end else begin
            phase_cnt <= phase_cnt - ONE;
          end
        end

        ST_HOLD: begin
          if (phase_last) begin
            state  <= ST_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt - ONE;
          end
        end

        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/switch_bounce_gen.md
# switch_bounce_gen

Synthesizable mechanical-switch emulator: on request it drives a single-bit switch line through a burst of pseudo-random glitches and then settles it at a target level. This is the transmitter end of the debounced-switch path. It feeds the debouncer's switch input for on-FPGA self-test and for closed-loop benches, reproducing in RTL the press/bounce stimulus pattern. Glitch widths come from a free-running LFSR, so a given seed always produces the same sequence.

## Interface
- `CNT_W`, 24: width of all duration fields and internal phase counter.
- `SEED`, 32'hACE1_0001: LFSR reset value; 0 is replaced by 1.
- `clk_i` in 1: single clock; all logic on rising edge.
- `rst_ni` in 1: reset, asynchronous assert, active-low.
- `start_i` in 1: request a bounce sequence; sampled only while idle.
- `level_i` in 1: target (settled) level of `sw_o`.
- `num_bounces_i` in 8: glitch pairs before settling; 0 is legal.
- `min_len_i` in CNT_W: minimum phase length in cycles; 0 treated as 1.
- `rand_mask_i` in CNT_W: mask applied to LFSR for the random part of each phase.
- `hold_i` in CNT_W: settled-level hold length in cycles; 0 treated as 1.
- `sw_o` out 1: emulated switch line, registered.
- `busy_o` out 1: sequence in progress.
- `done_o` out 1: one-cycle pulse when the sequence completes.

## Operation
- FSM states: IDLE, ON, OFF, HOLD, DONE.
- IDLE: `sw_o` keeps its last value. When `start_i`=1, the block latches `level_i`, `num_bounces_i`, `min_len_i`, `rand_mask_i` and `hold_i`.
  - If the latched bounce count is 0, go to HOLD.
  - Otherwise go to ON.
- ON: `sw_o`=target for d1 cycles, then go to OFF.
- OFF: `sw_o`=~target for d2 cycles, then decrement the bounce count.
  - Count 0 → HOLD.
  - Otherwise → ON.
- HOLD: `sw_o`=target for `hold` cycles, then go to DONE.
- DONE: one cycle with `done_o`=1 and `busy_o`=0; `sw_o`=target. `start_i` is accepted in this cycle exactly as in IDLE, otherwise go to IDLE.
- Phase length d = max(min,1) + (lfsr[CNT_W-1:0] & mask).
  - Computed in CNT_W+1 bits, saturated to 2^CNT_W-1.
  - Sampled on the cycle a phase is entered.
- LFSR: 32-bit Galois, taps 32'h8020_0003. It advances every cycle after reset, whether idle or busy, and is never zero.
- `start_i` during ON/OFF/HOLD is ignored; no queuing.
- Latched configuration is stable for the whole sequence; input changes mid-sequence have no effect.
- Reset at any point gives IDLE, `sw_o`=0, `busy_o`=0, `done_o`=0, counters cleared, LFSR=SEED. No done pulse is emitted for an aborted sequence.

## Timing
- Reset values: `sw_o`=0, `busy_o`=0, `done_o`=0.
- `start_i` high in cycle N: the first phase value appears on `sw_o` and `busy_o`=1 from cycle N+1.
- A phase of length d holds `sw_o` for exactly d cycles. The next phase's value appears in the following cycle, so there are no dead cycles between phases.
- Total busy cycles = Σ(d1+d2) + hold. `done_o` is in the cycle immediately after the last busy cycle.
- Back-to-back: `start_i` held high gives DONE→ON/HOLD with one non-busy cycle (DONE) between sequences.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `switch_bounce_pkg` contains:
  - the FSM state enum `bounce_state_e`;
  - LFSR width and tap constant `LFSR_TAPS`;
  - `DEFAULT_SEED`.
- One sub-module, `lfsr_galois`, with parameters width, taps and seed, a free-running enable and a parallel-out output.
- The top level holds the FSM, the phase down-counter, the bounce down-counter, the length adder/saturator and the config latches.

## Test plan
- Reset mid-sequence: start with `num_bounces_i`=5 and `min_len_i`=100. Assert `rst_ni`=0 in the third phase. Required: `sw_o`=0, `busy_o`=0 asynchronously, no `done_o`, and LFSR back to SEED.
- Zero bounces: `num_bounces_i`=0, `hold_i`=50, `level_i`=1.
  - `sw_o`=1 for exactly 50 cycles from N+1.
  - `done_o` at N+51.
  - `busy_o` high for exactly 50 cycles.
- Deterministic widths: `rand_mask_i`=0, `min_len_i`=10, `num_bounces_i`=3, `hold_i`=20, `level_i`=1.
  - `sw_o` pattern: 1×10, 0×10 repeated three times, then 1×20.
  - `done_o` at N+81.
- Randomized run against the debouncer: 1000 sequences with `rand_mask_i`=16'h0FFF, `min_len_i`=256 and `hold_i` greater than the debounce time. Required: exactly one debounced tick per sequence.
  - Every measured phase lies in [256, 4351].
  - Sequences repeat identically after reset with the same SEED.
- Ignore and back-to-back starts:
  - `start_i` pulses during OFF are ignored; the sequence length is unchanged.
  - `start_i` held high gives a DONE cycle, then a new sequence starting the next cycle.
- Edge values:
  - `min_len_i`=0 and `hold_i`=0 behave as 1.
  - `min_len_i`=2^24-1 with `rand_mask_i`=all ones saturates each phase to 2^24-1 cycles.
  - `num_bounces_i`=255 completes with 510 glitch phases.
